// File: rtl/trng_pkg.sv
// Shared constants for the trng arbiter: FSM state encoding and default sizing.
package trng_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DELIVER = 3'd4;

  localparam int TRNG_W      = 8;
  localparam int TMO_CYC_DEF = 4096;
  localparam int REP_LIM_DEF = 4;

endpackage

// File: rtl/trng_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after i_rr_ptr, circularly.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_rr_ptr) + k) % N_REQ]) begin
        o_winner = IDX_W'((int'(i_rr_ptr) + k) % N_REQ);
        o_any    = 1'b1;
      end else begin
        o_winner = o_winner;
      end
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one trng core among N_REQ requesters: round-robin grant, one run per grant,
// timeout abort and a repetition-count health test on delivered bytes.
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = TRNG_W,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int REP_LIM = REP_LIM_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_REQ-1:0]  i_req,
  output logic [N_REQ-1:0]  o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_trng_start,
  input  logic              i_trng_done,
  input  logic [DATA_W-1:0] i_trng_data,
  output logic              o_busy,
  output logic              o_tmo_err,
  output logic              o_health_fail
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 1);
  localparam logic [3:0]       REP_LIM_V = 4'(REP_LIM);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_winner;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [DATA_W-1:0] r_cap;
  logic [DATA_W-1:0] r_last_byte;
  logic [3:0]        r_rep_cnt;
  logic              r_done_q;
  logic              r_tmo_err;
  logic              r_health_fail;

  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_done_rise;
  logic              w_tmo_hit;
  logic              w_deliver_ok;
  logic [3:0]        w_rep_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_done_rise  = i_trng_done & ~r_done_q;
  assign w_tmo_hit    = (r_tmo_cnt == TMO_LAST);
  assign w_deliver_ok = i_req[r_winner];
  // Repetition count saturates at 15 so it never wraps back below the limit.
  assign w_rep_next   = (r_cap == r_last_byte) ?
                        ((r_rep_cnt == 4'd15) ? 4'd15 : r_rep_cnt + 4'd1) : 4'd1;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_any && !r_health_fail) w_next_state = S_START;
        else                              w_next_state = S_IDLE;
      end
      S_START: w_next_state = S_WAIT;
      S_WAIT: begin
        if (w_done_rise)    w_next_state = S_CHECK;
        else if (w_tmo_hit) w_next_state = S_IDLE;
        else                w_next_state = S_WAIT;
      end
      S_CHECK: begin
        if (w_rep_next == REP_LIM_V) w_next_state = S_IDLE;
        else                         w_next_state = S_DELIVER;
      end
      S_DELIVER: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_ack        = '0;
    o_rdata      = '0;
    o_trng_start = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_START: o_trng_start = 1'b1;
      S_DELIVER: begin
        if (w_deliver_ok) begin
          o_ack[r_winner] = 1'b1;
          o_rdata         = r_cap;
        end else begin
          o_ack = '0;
        end
      end
      default: o_trng_start = 1'b0;
    endcase
  end

  // Winner, timeout counter, captured byte, health test and pointer bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rr_ptr      <= '0;
      r_winner      <= '0;
      r_tmo_cnt     <= '0;
      r_cap         <= '0;
      r_last_byte   <= '0;
      r_rep_cnt     <= 4'd0;
      r_done_q      <= 1'b0;
      r_tmo_err     <= 1'b0;
      r_health_fail <= 1'b0;
    end else begin
      r_done_q <= i_trng_done;
      case (r_state)
        S_IDLE: begin
          if (w_pick_any && !r_health_fail) r_winner <= w_pick_idx;
        end
        S_START: r_tmo_cnt <= '0;
        S_WAIT: begin
          if (w_done_rise) begin
            r_cap     <= i_trng_data;
            r_tmo_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_tmo_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        S_CHECK: begin
          r_rep_cnt   <= w_rep_next;
          r_last_byte <= r_cap;
          if (w_rep_next == REP_LIM_V) r_health_fail <= 1'b1;
        end
        S_DELIVER: begin
          r_rr_ptr <= (r_winner == IDX_W'(N_REQ - 1)) ? '0 : r_winner + IDX_W'(1);
        end
        default: r_tmo_cnt <= '0;
      endcase
    end
  end

  assign o_tmo_err     = r_tmo_err;
  assign o_health_fail = r_health_fail;

endmodule
